// File: rtl/count_monitor_pkg.sv
// -----------------------------------------------------------------------------
// count_monitor_pkg
// Shared types and constants for count_event_monitor and its match detector.
//   state_e     : monitor FSM state (IDLE, CLEAR, RUN, DONE)
//   RSN_*       : done_reason encodings
//   DEF_*       : default parameter values
//   reason_f    : folds the stop/target end causes into a done_reason code
// -----------------------------------------------------------------------------
package count_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [1:0] RSN_TIMEOUT = 2'b00;
  localparam logic [1:0] RSN_TARGET  = 2'b01;
  localparam logic [1:0] RSN_STOP    = 2'b10;
  localparam logic [1:0] RSN_BOTH    = 2'b11;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_EVT_W      = 4;
  localparam int DEF_WRAP_LIMIT = 4;

  // Bit 0 flags the target, bit 1 flags stop; neither means timeout.
  function automatic logic [1:0] reason_f(input logic by_target, input logic by_stop);
    return {by_stop, by_target};
  endfunction

endpackage

// File: rtl/count_event_monitor_if.sv
// -----------------------------------------------------------------------------
// count_event_monitor_if
// Bundles the run-control handshake, the counter loop and the status outputs.
//   start/stop/threshold/target_evts : run control (driven by master)
//   count_in                         : counter value (driven by master side)
//   cnt_en/cnt_rst                   : counter control (driven by slave)
//   match/wrap/evt_count             : event observation (driven by slave)
//   busy/done/done_reason/done_ack   : completion handshake
//
// Handshake: start is a request taken only while the monitor is idle (busy=0,
// done=0); a run ends by raising done, which stays high together with
// done_reason and evt_count until done_ack is seen high at a rising edge, after
// which the monitor returns to idle. stop is honoured only while running.
//
// Modports: master = environment / test harness, slave = the monitor.
// -----------------------------------------------------------------------------
interface count_event_monitor_if #(
  parameter int WIDTH = 8,
  parameter int EVT_W = 4
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] threshold;
  logic [EVT_W-1:0] target_evts;
  logic [WIDTH-1:0] count_in;
  logic             cnt_en;
  logic             cnt_rst;
  logic             match;
  logic             wrap;
  logic [EVT_W-1:0] evt_count;
  logic             busy;
  logic             done;
  logic [1:0]       done_reason;
  logic             done_ack;

  modport master (
    output start, stop, threshold, target_evts, count_in, done_ack,
    input  cnt_en, cnt_rst, match, wrap, evt_count, busy, done, done_reason
  );

  modport slave (
    input  start, stop, threshold, target_evts, count_in, done_ack,
    output cnt_en, cnt_rst, match, wrap, evt_count, busy, done, done_reason
  );
endinterface

// File: rtl/count_match_detect.sv
// -----------------------------------------------------------------------------
// count_match_detect
// Tracks the previous counter sample and detects threshold matches and
// all-ones -> zero wraps while the monitor is running.
//   clk, rst     : clock, asynchronous active-high reset
//   run_i        : monitor is in RUN (detection and sampling enabled)
//   clear_i      : monitor is in CLEAR (forget the previous sample)
//   count_i      : counter value
//   thr_i        : latched threshold
//   hit_o        : combinational match qualification for this cycle
//   wrap_hit_o   : combinational wrap qualification for this cycle
//   match_o      : registered one-cycle match pulse
//   wrap_o       : registered one-cycle wrap pulse
// -----------------------------------------------------------------------------
module count_match_detect #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] thr_i,
  output logic             hit_o,
  output logic             wrap_hit_o,
  output logic             match_o,
  output logic             wrap_o
);

  logic [WIDTH-1:0] prev_count_q, prev_count_d;
  logic             prev_valid_q, prev_valid_d;
  logic             match_q, match_d;
  logic             wrap_q, wrap_d;

  // A match is an arrival at the threshold: a counter parked on the threshold
  // value counts once, not once per cycle. The first sample after CLEAR has
  // no history and qualifies on equality alone.
  assign hit_o = run_i && (count_i == thr_i) &&
                 (!prev_valid_q || (prev_count_q != thr_i));

  assign wrap_hit_o = run_i && prev_valid_q && (&prev_count_q) && (count_i == '0);

  always_comb begin
    prev_count_d = prev_count_q;
    prev_valid_d = prev_valid_q;
    match_d      = hit_o;
    wrap_d       = wrap_hit_o;
    if (clear_i) begin
      prev_valid_d = 1'b0;
    end else if (run_i) begin
      prev_count_d = count_i;
      prev_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_count_q <= '0;
      prev_valid_q <= 1'b0;
      match_q      <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      prev_count_q <= prev_count_d;
      prev_valid_q <= prev_valid_d;
      match_q      <= match_d;
      wrap_q       <= wrap_d;
    end
  end

  assign match_o = match_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/count_event_monitor.sv
// -----------------------------------------------------------------------------
// count_event_monitor
// Drives an external 8-bit enable counter (enable + synchronous clear), watches
// its output for threshold matches and wraps, accumulates matches up to a
// programmed target and reports completion through a done/done_ack handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : count_event_monitor_if.slave (control, counter loop, status)
//   state_o  : FSM state for observation
//
// Optional build macro COUNT_MONITOR_WRAP_LIMIT_EN: adds a wrap counter that
// ends a run with reason 00 (timeout) after WRAP_LIMIT wraps. Without it a run
// with target 0 ends only on stop.
// -----------------------------------------------------------------------------
module count_event_monitor
  import count_monitor_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int EVT_W      = DEF_EVT_W,
  parameter int WRAP_LIMIT = DEF_WRAP_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  count_event_monitor_if.slave  bus,
  output state_e                state_o
);

  localparam logic [EVT_W-1:0] EVT_MAX = '1;
  localparam logic [EVT_W-1:0] EVT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] thr_q, thr_d;
  logic [EVT_W-1:0] tgt_q, tgt_d;
  logic [EVT_W-1:0] evt_q, evt_d;
  logic [1:0]       rsn_q, rsn_d;

  logic             run_w;
  logic             clear_w;
  logic             hit_w;
  logic             wrap_hit_w;
  logic             match_w;
  logic             wrap_w;
  logic [EVT_W-1:0] evt_inc;
  logic             tgt_hit;

`ifdef COUNT_MONITOR_WRAP_LIMIT_EN
  localparam int             WC_W      = $clog2(WRAP_LIMIT + 1);
  localparam logic [WC_W-1:0] WRAP_LIM_C = WC_W'(WRAP_LIMIT);
  localparam logic [WC_W-1:0] WC_ONE     = {{(WC_W-1){1'b0}}, 1'b1};

  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [WC_W-1:0] wcnt_inc;

  assign wcnt_inc = wcnt_q + WC_ONE;
`else
  localparam int unused_wrap_limit = WRAP_LIMIT;
`endif

  assign run_w   = (state_q == RUN);
  assign clear_w = (state_q == CLEAR);

  count_match_detect #(
    .WIDTH (WIDTH)
  ) u_detect (
    .clk        (clk),
    .rst        (rst),
    .run_i      (run_w),
    .clear_i    (clear_w),
    .count_i    (bus.count_in),
    .thr_i      (thr_q),
    .hit_o      (hit_w),
    .wrap_hit_o (wrap_hit_w),
    .match_o    (match_w),
    .wrap_o     (wrap_w)
  );

  // Saturating increment: the match count sticks at all-ones.
  assign evt_inc = (evt_q == EVT_MAX) ? evt_q : (evt_q + EVT_ONE);

  // Target 0 means unlimited, so it can never be "reached".
  assign tgt_hit = hit_w && (tgt_q != '0) && (evt_inc == tgt_q);

  always_comb begin
    state_d = state_q;
    thr_d   = thr_q;
    tgt_d   = tgt_q;
    evt_d   = evt_q;
    rsn_d   = rsn_q;
`ifdef COUNT_MONITOR_WRAP_LIMIT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          thr_d   = bus.threshold;
          tgt_d   = bus.target_evts;
          evt_d   = '0;
          rsn_d   = RSN_TIMEOUT;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
`ifdef COUNT_MONITOR_WRAP_LIMIT_EN
        wcnt_d  = '0;
`endif
        state_d = RUN;
      end
      RUN: begin
        if (hit_w) begin
          evt_d = evt_inc;
        end
`ifdef COUNT_MONITOR_WRAP_LIMIT_EN
        if (wrap_hit_w) begin
          wcnt_d = wcnt_inc;
        end
`endif
        // Stop and target outrank the wrap timeout when they coincide.
        if (bus.stop || tgt_hit) begin
          rsn_d   = reason_f(tgt_hit, bus.stop);
          state_d = DONE;
        end
`ifdef COUNT_MONITOR_WRAP_LIMIT_EN
        else if (wrap_hit_w && (wcnt_inc == WRAP_LIM_C)) begin
          rsn_d   = RSN_TIMEOUT;
          state_d = DONE;
        end
`endif
      end
      DONE: begin
        if (bus.done_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      thr_q   <= '0;
      tgt_q   <= '0;
      evt_q   <= '0;
      rsn_q   <= RSN_TIMEOUT;
    end else begin
      state_q <= state_d;
      thr_q   <= thr_d;
      tgt_q   <= tgt_d;
      evt_q   <= evt_d;
      rsn_q   <= rsn_d;
    end
  end

`ifdef COUNT_MONITOR_WRAP_LIMIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`endif

  // Counter control decodes straight from the state register.
  assign bus.cnt_en      = run_w;
  assign bus.cnt_rst     = clear_w;
  assign bus.match       = match_w;
  assign bus.wrap        = wrap_w;
  assign bus.evt_count   = evt_q;
  assign bus.busy        = clear_w || run_w;
  assign bus.done        = (state_q == DONE);
  assign bus.done_reason = rsn_q;
  assign state_o         = state_q;

endmodule
